// File: rtl/mem_bus_pkg.sv
// Shared types for the memory bus arbiter: FSM states, owner encoding and the
// default anti-starvation limit.
package mem_bus_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_t;

  typedef enum logic {
    OWN_INST = 1'b0,
    OWN_DATA = 1'b1
  } owner_t;

  localparam int STARVE_LIMIT_DEFAULT = 2;

endpackage

// File: rtl/mem_bus_grant.sv
// Priority decision between fetch and data requests: data wins, except that
// fetch wins once it has been passed over STARVE_LIMIT times in a row.
module mem_bus_grant
  import mem_bus_pkg::*;
#(
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic inst_req,
  input  logic data_req,
  output logic grant_inst,
  output logic grant_data
);

  localparam int CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] starve_cnt;
  logic             inst_wins;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

  always_comb begin
    inst_wins  = inst_req && (!data_req || (starve_cnt == CNT_MAX));
    grant_inst = en && inst_wins;
    grant_data = en && data_req && !inst_wins;
  end

  // Counts consecutive data grants taken while a fetch was waiting.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (grant_inst) begin
      starve_cnt <= '0;
    end else if (grant_data) begin
      starve_cnt <= inst_req ? sat_inc(starve_cnt) : '0;
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one SRAM-like memory port between instruction fetch and the data
// path, one outstanding transaction at a time, routing responses to the owner.
module mem_bus_arbiter
  import mem_bus_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEFAULT
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                inst_req,
  input  logic [ADDR_W-1:0]   inst_addr,
  output logic                inst_addr_ok,
  output logic                inst_data_ok,
  output logic [DATA_W-1:0]   inst_rdata,
  input  logic                data_req,
  input  logic                data_wr,
  input  logic [DATA_W/8-1:0] data_wstrb,
  input  logic [ADDR_W-1:0]   data_addr,
  input  logic [DATA_W-1:0]   data_wdata,
  output logic                data_addr_ok,
  output logic                data_data_ok,
  output logic [DATA_W-1:0]   data_rdata,
  output logic                bus_req,
  output logic                bus_wr,
  output logic [DATA_W/8-1:0] bus_wstrb,
  output logic [ADDR_W-1:0]   bus_addr,
  output logic [DATA_W-1:0]   bus_wdata,
  input  logic                bus_addr_ok,
  input  logic                bus_data_ok,
  input  logic [DATA_W-1:0]   bus_rdata
);

  state_t state;
  state_t state_nxt;
  owner_t owner;
  logic   grant_en;
  logic   grant_inst;
  logic   grant_data;
  logic   done;

  // Grants only in IDLE; holding off during reset keeps every addr_ok low.
  assign grant_en = (state == IDLE) && !rst;

  mem_bus_grant #(
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_grant (
    .clk        (clk),
    .rst        (rst),
    .en         (grant_en),
    .inst_req   (inst_req),
    .data_req   (data_req),
    .grant_inst (grant_inst),
    .grant_data (grant_data)
  );

  always_comb begin
    state_nxt    = state;
    done         = 1'b0;
    inst_addr_ok = grant_inst;
    data_addr_ok = grant_data;
    bus_req      = (state == REQ);
    case (state)
      IDLE: begin
        if (grant_inst || grant_data) state_nxt = REQ;
      end
      REQ: begin
        if (bus_addr_ok) begin
          if (bus_data_ok) begin
            done      = 1'b1;
            state_nxt = IDLE;
          end else begin
            state_nxt = WAIT;
          end
        end
      end
      WAIT: begin
        if (bus_data_ok) begin
          done      = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    inst_data_ok = done && (owner == OWN_INST);
    data_data_ok = done && (owner == OWN_DATA);
    inst_rdata   = inst_data_ok ? bus_rdata : '0;
    data_rdata   = data_data_ok ? bus_rdata : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Request fields are captured at grant so requesters may move on after addr_ok.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner     <= OWN_INST;
      bus_wr    <= 1'b0;
      bus_wstrb <= '0;
      bus_addr  <= '0;
      bus_wdata <= '0;
    end else if (grant_data) begin
      owner     <= OWN_DATA;
      bus_wr    <= data_wr;
      bus_wstrb <= data_wstrb;
      bus_addr  <= data_addr;
      bus_wdata <= data_wdata;
    end else if (grant_inst) begin
      owner     <= OWN_INST;
      bus_wr    <= 1'b0;
      bus_wstrb <= '0;
      bus_addr  <= inst_addr;
      bus_wdata <= '0;
    end
  end

endmodule
